fb_stream_reader: RTL

- Read side of the camera frame buffer (128 KB byte-addressed SPRAM store).
- On a start command, walks a byte range of the buffer by driving rd_addr, compensates for the store's read latency, and presents the bytes as a valid/ready byte stream with a last flag to the JPEG encoder / ESP32 link.
- Yields to the capture writer: any read disturbed by wr_en is discarded and replayed.

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_byte_fifo.sv | 59 +++++
 rtl/fb_stream_reader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: default address width, store size, reader FSM encoding.
package fb_pkg;

  localparam int AW_DEF   = 17;
  localparam int FB_BYTES = 2 ** AW_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_byte_fifo.sv
// Synchronous byte FIFO with a per-entry last flag and occupancy count; head is shown directly from storage.
// Latency: a pushed byte is visible at the head one cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; flush empties it in one cycle.
module fb_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     push_last,
  input  logic                     pop,
  output logic [7:0]               head_data,
  output logic                     head_last,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]       mem_data [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem_data[rd_ptr];
  assign head_last = mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_last <= '0;
      for (int i = 0; i < DEPTH; i++) mem_data[i] <= 8'h00;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_data[wr_ptr] <= push_data;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fb_stream_reader.sv
// Frame-buffer read side: walks a byte range, hides SPRAM read latency, streams bytes with last/done.
// Latency: first m_valid RD_LAT+1 cycles after start; 1 byte/cycle while m_ready=1 and the writer is idle.
// Backpressure: m_ready low holds data/last; issue stalls once FIFO occupancy + in-flight reads reach FIFO_DEPTH.
// Optional FB_RD_CHECKSUM_EN adds csum, a 16-bit wrapping sum of transferred bytes.
module fb_stream_reader
  import fb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          rd_clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  input  logic          abort,
  input  logic          wr_en_mon,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          done
`ifdef FB_RD_CHECKSUM_EN
  ,
  output logic [15:0]   csum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fb_state_e     state;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] deliver_addr;
  logic [AW-1:0] issue_cnt;
  logic [AW-1:0] deliver_cnt;
  logic [AW-1:0] len_r;
  logic [RD_LAT-1:0] pipe;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          head_last;
  logic [CW:0]   inflight;
  logic [CW:0]   occupancy;
  logic          collide;
  logic          issue;
  logic          push;
  logic          xfer;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + (CW+1)'(pipe[i]);
  end

  assign occupancy = {1'b0, fifo_count} + inflight;
  // Any writer cycle while reads are in flight poisons them all; the exiting byte included.
  assign collide   = wr_en_mon & (|pipe);
  assign issue     = (state == RUN) & ~wr_en_mon & (issue_cnt != len_r)
                   & (occupancy < (CW+1)'(FIFO_DEPTH));
  assign push      = pipe[RD_LAT-1] & ~collide;
  assign xfer      = m_valid & m_ready;

  assign rd_addr = issue_addr;
  assign m_valid = ~fifo_empty;
  assign m_last  = m_valid & head_last;

  fb_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (rd_clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .push      (push),
    .push_data (rd_data),
    .push_last (deliver_cnt == len_r - 1'b1),
    .pop       (xfer),
    .head_data (m_data),
    .head_last (head_last),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge rd_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      issue_addr   <= '0;
      deliver_addr <= '0;
      issue_cnt    <= '0;
      deliver_cnt  <= '0;
      len_r        <= '0;
      pipe         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        pipe  <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (length == '0) begin
                done <= 1'b1;
              end else begin
                issue_addr   <= base_addr;
                deliver_addr <= base_addr;
                issue_cnt    <= '0;
                deliver_cnt  <= '0;
                len_r        <= length;
                busy         <= 1'b1;
                state        <= RUN;
              end
            end
          end
          default: begin
            if (collide) begin
              // Replay from the first byte not yet safely captured.
              pipe       <= '0;
              issue_addr <= deliver_addr;
              issue_cnt  <= deliver_cnt;
              state      <= RUN;
            end else begin
              pipe <= (pipe << 1) | RD_LAT'(issue);
              if (issue) begin
                issue_addr <= issue_addr + 1'b1;
                issue_cnt  <= issue_cnt + 1'b1;
                if (issue_cnt + 1'b1 == len_r) state <= DRAIN;
              end
              if (push) begin
                deliver_addr <= deliver_addr + 1'b1;
                deliver_cnt  <= deliver_cnt + 1'b1;
              end
            end
            if (xfer && m_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef FB_RD_CHECKSUM_EN
  always_ff @(posedge rd_clk) begin
    if (!reset_n)                             csum <= 16'h0000;
    else if (abort)                           csum <= csum;
    else if (state == IDLE && start)          csum <= 16'h0000;
    else if (xfer)                            csum <= csum + 16'(m_data);
  end
`endif

endmodule
